inv_bist_ctrl: RTL

INV_BIST_CTRL -- requirements
Module: inv_bist_ctrl

---
 rtl/inv_bist_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/inv_bist_ctrl.sv
// -----------------------------------------------------------------------------
// inv_bist_ctrl
//
// Built-in self-test controller for a bank of WIDTH inverters. A run applies
// N = 2*WIDTH+2 vectors (all zeros, all ones, walking one, walking zero). Each
// vector is held for SETTLE cycles and then compared in a single CHECK cycle
// against the expected bitwise inverse. The controller records the mismatch
// count, the index of the first failing vector, and an overall pass flag.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   level run request, only looked at while idle
//   dut_nota  in   [WIDTH] inverter bank output (combinational from dut_a)
//   dut_a     out  [WIDTH] registered stimulus to the inverter bank
//   busy      out  high while a run is applying/checking vectors
//   done      out  one-cycle pulse when a run completes
//   pass      out  1 when the last completed run saw no mismatches
//   err_cnt   out  [8] mismatch count of the current/last run (saturating)
//   fail_idx  out  [8] first failing vector index, 8'hFF when none
// -----------------------------------------------------------------------------
module inv_bist_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dut_nota,
  output logic [WIDTH-1:0] dut_a,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt,
  output logic [7:0]       fail_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX    = 8'(2 * WIDTH + 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [7:0] NO_FAIL     = 8'hFF;

  // Test vector for a given index: 0 -> zeros, 1 -> ones, then a walking one
  // across every bit, then a walking zero across every bit.
  function automatic logic [WIDTH-1:0] pattern(input logic [7:0] idx);
    logic [WIDTH-1:0] p;
    int               i_int;
    i_int = int'(idx);
    p     = '0;
    if (i_int == 1) begin
      p = '1;
    end else if (i_int >= 2 && i_int < WIDTH + 2) begin
      for (int b = 0; b < WIDTH; b++) p[b] = (b == i_int - 2);
    end else if (i_int >= WIDTH + 2) begin
      for (int b = 0; b < WIDTH; b++) p[b] = (b != i_int - WIDTH - 2);
    end
    return p;
  endfunction

  state_t           state, state_nxt;
  logic [7:0]       vec_idx, vec_idx_nxt;
  logic [3:0]       wait_cnt, wait_cnt_nxt;
  logic [WIDTH-1:0] dut_a_nxt;
  logic [7:0]       err_cnt_nxt, fail_idx_nxt;
  logic             pass_nxt;
  logic             mismatch;

  assign mismatch = (dut_nota != ~dut_a);

  // Status flags decode straight from the state register, so they change
  // only on clock edges.
  assign busy = (state == APPLY) || (state == CHECK);
  assign done = (state == DONE);

  // NOTE: every variable gets its default before the case statement; any
  // path that left one unassigned would infer a latch.
  always_comb begin
    state_nxt    = state;
    vec_idx_nxt  = vec_idx;
    wait_cnt_nxt = wait_cnt;
    dut_a_nxt    = dut_a;
    err_cnt_nxt  = err_cnt;
    fail_idx_nxt = fail_idx;
    pass_nxt     = pass;

    case (state)
      IDLE: begin
        dut_a_nxt = '0;
        if (start) begin
          state_nxt    = APPLY;
          vec_idx_nxt  = '0;
          dut_a_nxt    = pattern(8'd0);
          wait_cnt_nxt = '0;
          err_cnt_nxt  = '0;
          fail_idx_nxt = NO_FAIL;
          pass_nxt     = 1'b0;
        end
      end

      APPLY: begin
        wait_cnt_nxt = wait_cnt + 4'd1;
        if (wait_cnt == SETTLE_LAST) state_nxt = CHECK;
      end

      CHECK: begin
        if (mismatch) begin
          if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
          if (fail_idx == NO_FAIL) fail_idx_nxt = vec_idx;
        end
        if (vec_idx == LAST_IDX) begin
          state_nxt = DONE;
          dut_a_nxt = '0;
          // The last vector's own mismatch has not reached err_cnt yet.
          pass_nxt  = (err_cnt == 8'd0) && !mismatch;
        end else begin
          state_nxt    = APPLY;
          vec_idx_nxt  = vec_idx + 8'd1;
          dut_a_nxt    = pattern(vec_idx + 8'd1);
          wait_cnt_nxt = '0;
        end
      end

      DONE: begin
        state_nxt = IDLE;
        dut_a_nxt = '0;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec_idx  <= '0;
      wait_cnt <= '0;
      dut_a    <= '0;
      err_cnt  <= '0;
      fail_idx <= NO_FAIL;
      pass     <= 1'b0;
    end else begin
      state    <= state_nxt;
      vec_idx  <= vec_idx_nxt;
      wait_cnt <= wait_cnt_nxt;
      dut_a    <= dut_a_nxt;
      err_cnt  <= err_cnt_nxt;
      fail_idx <= fail_idx_nxt;
      pass     <= pass_nxt;
    end
  end

endmodule
